// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 32 x 32 register file: zero-fills r1..r(NREGS-1)
// after reset, then round-robin arbitrates NREQ requesters onto the single write port.
module regfile_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int ADDRW = 5,
    parameter int NREGS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    RegWrite,
    output logic [ADDRW-1:0]        WriteRegister,
    output logic [WIDTH-1:0]        WriteData
);
    localparam int PTRW = $clog2(NREQ);
    localparam int CNTW = ADDRW + 1;

    typedef enum logic {CLEAR, ARB} state_t;

    state_t            state, state_n;
    logic [CNTW-1:0]   cnt, cnt_n;
    logic [PTRW-1:0]   ptr, ptr_n;
    logic [NREQ-1:0]   grant_n;
    logic [NREQ-1:0]   eligible;
    logic              reg_write_n;
    logic [ADDRW-1:0]  write_register_n;
    logic [WIDTH-1:0]  write_data_n;
    logic              busy_n;
    logic              found;
    int                idx;

    // Handshake: req[i] is held with stable addr/data until grant[i] is seen
    // high for one cycle; that requester is masked from the very next decision
    // because it only updates its request at the edge where grant is visible.
    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        ptr_n            = ptr;
        grant_n          = '0;
        reg_write_n      = 1'b0;
        write_register_n = WriteRegister;
        write_data_n     = WriteData;
        busy_n           = busy;
        eligible         = req & ~grant;
        found            = 1'b0;
        idx              = 0;
        case (state)
            CLEAR: begin
                if (cnt == CNTW'(NREGS)) begin
                    state_n = ARB;
                    busy_n  = 1'b0;
                end else begin
                    reg_write_n      = 1'b1;
                    write_register_n = cnt[ADDRW-1:0];
                    write_data_n     = '0;
                    cnt_n            = cnt + 1'b1;
                    busy_n           = 1'b1;
                end
            end
            ARB: begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (int'(ptr) + k) % NREQ;
                    if (!found && eligible[idx]) begin
                        found            = 1'b1;
                        grant_n[idx]     = 1'b1;
                        write_register_n = req_addr[idx*ADDRW +: ADDRW];
                        write_data_n     = req_data[idx*WIDTH +: WIDTH];
                        // r0 is hardwired zero: the request is consumed without a write.
                        reg_write_n      = (req_addr[idx*ADDRW +: ADDRW] != '0);
                        ptr_n            = PTRW'((idx + 1) % NREQ);
                    end
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CLEAR;
            cnt           <= CNTW'(1);
            ptr           <= '0;
            grant         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            busy          <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            ptr           <= ptr_n;
            grant         <= grant_n;
            RegWrite      <= reg_write_n;
            WriteRegister <= write_register_n;
            WriteData     <= write_data_n;
            busy          <= busy_n;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sequence, masking, round-robin
// order, r0 writes and reset in both phases, against hand-computed values.
module tb_regfile_write_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int ADDRW = 5;
    localparam int NREGS = 32;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  RegWrite;
    logic [ADDRW-1:0]      WriteRegister;
    logic [WIDTH-1:0]      WriteData;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    regfile_write_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .ADDRW(ADDRW), .NREGS(NREGS)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_data(req_data), .grant(grant), .busy(busy), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, required completion", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic rw,
                           input logic [31:0] wr, input logic [31:0] wd, input logic b);
        check({tag, ".grant"},    32'(grant),         32'(g));
        check({tag, ".regwrite"}, 32'(RegWrite),      32'(rw));
        check({tag, ".wreg"},     32'(WriteRegister), wr);
        check({tag, ".wdata"},    WriteData,          wd);
        check({tag, ".busy"},     32'(busy),          32'(b));
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDRW-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*ADDRW +: ADDRW] = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic run_clear(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) exp_q.push_back(32'(i));
        for (int i = first; i <= last; i++) begin
            tick();
            chk_out(tag, 4'b0000, 1'b1, exp_q.pop_front(), 32'h0, 1'b1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 1'b0, 32'd0, 32'h0, 1'b1);

        // request held through the clear must be served right after it
        set_req(2, 5'd5, 32'hDEADBEEF);
        req   = 4'b0100;
        reset = 1'b0;
        run_clear(1, NREGS - 1, "clear");
        tick();
        chk_out("clear_done", 4'b0000, 1'b0, 32'd31, 32'h0, 1'b0);

        tick();
        chk_out("single_grant", 4'b0100, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
        tick();
        chk_out("single_masked", 4'b0000, 1'b0, 32'd5, 32'hDEADBEEF, 1'b0);
        tick();
        chk_out("single_regrant", 4'b0100, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("idle_hold", 4'b0000, 1'b0, 32'd5, 32'hDEADBEEF, 1'b0);

        // write to r0 is consumed without RegWrite; pointer 3 -> wins 0 -> pointer 1
        set_req(0, 5'd0, 32'h12345678);
        req = 4'b0001;
        tick();
        chk_out("r0_grant", 4'b0001, 1'b0, 32'd0, 32'h12345678, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("r0_idle", 4'b0000, 1'b0, 32'd0, 32'h12345678, 1'b0);

        set_req(0, 5'd3, 32'hA0A0A0A0);
        set_req(1, 5'd4, 32'hB1B1B1B1);
        req = 4'b0011;
        tick();
        chk_out("ptr_after_r0", 4'b0010, 1'b1, 32'd4, 32'hB1B1B1B1, 1'b0);
        tick();
        chk_out("ptr_next", 4'b0001, 1'b1, 32'd3, 32'hA0A0A0A0, 1'b0);
        req = 4'b0000;
        tick();

        set_req(3, 5'd7, 32'hC3C3C3C3);
        req = 4'b1000;
        tick();
        chk_out("req3", 4'b1000, 1'b1, 32'd7, 32'hC3C3C3C3, 1'b0);
        req = 4'b0000;
        tick();

        // pointer now 0: 1 and 3 alternate
        req = 4'b1010;
        tick();
        chk_out("alt0", 4'b0010, 1'b1, 32'd4, 32'hB1B1B1B1, 1'b0);
        tick();
        chk_out("alt1", 4'b1000, 1'b1, 32'd7, 32'hC3C3C3C3, 1'b0);
        tick();
        chk_out("alt2", 4'b0010, 1'b1, 32'd4, 32'hB1B1B1B1, 1'b0);
        tick();
        chk_out("alt3", 4'b1000, 1'b1, 32'd7, 32'hC3C3C3C3, 1'b0);
        req = 4'b0000;
        tick();

        // all four requesting: strict rotation, pointer starts at 0
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(8 + i), 32'h10000000 + 32'(i));
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out("rr", 4'(1 << (k % 4)), 1'b1, 32'(8 + (k % 4)),
                    32'h10000000 + 32'(k % 4), 1'b0);
        end

        // reset during active grants with requests still high
        reset = 1'b1;
        tick();
        chk_out("reset_arb", 4'b0000, 1'b0, 32'd0, 32'h0, 1'b1);
        reset = 1'b0;
        req   = 4'b0000;
        run_clear(1, 10, "clear2");
        reset = 1'b1;
        tick();
        chk_out("reset_clear", 4'b0000, 1'b0, 32'd0, 32'h0, 1'b1);
        reset = 1'b0;
        run_clear(1, NREGS - 1, "clear3");
        tick();
        chk_out("clear3_done", 4'b0000, 1'b0, 32'd31, 32'h0, 1'b0);

        // pointer must be back at 0 after reset
        set_req(1, 5'd4, 32'hB1B1B1B1);
        set_req(3, 5'd7, 32'hC3C3C3C3);
        req = 4'b1010;
        tick();
        chk_out("ptr_reset", 4'b0010, 1'b1, 32'd4, 32'hB1B1B1B1, 1'b0);
        req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
